// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Decode-stage interlock and multi-cycle writeback sequencer. Stalls ID on
//   load-use hazards, on reads/writes of registers still owed by an in-flight
//   multi-cycle op, and on a second multi-cycle op while the unit is busy.
//   It also launches the multi-cycle unit and announces its writeback register.
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   ID_*                 : decode-stage instruction fields
//   EX_MemRead/EX_WriteRegister/EX_BranchTaken : execute-stage status
//   PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush : pipeline control (combinational)
//   MC_Start, MC_Done, MC_WriteRegister, MC_Busy : multi-cycle unit sequencing
//   Pending              : per-register "result owed by multi-cycle op" bits
//   StallCycles          : saturating stall-cycle counter
module hazard_scoreboard #(
  parameter int MC_LAT = 4,
  parameter int NREG   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ID_Valid,
  input  logic [4:0]      ID_rs,
  input  logic [4:0]      ID_rt,
  input  logic            ID_UseRs,
  input  logic            ID_UseRt,
  input  logic            ID_MultiCycle,
  input  logic            ID_RegWrite,
  input  logic [4:0]      ID_WriteRegister,
  input  logic            EX_MemRead,
  input  logic [4:0]      EX_WriteRegister,
  input  logic            EX_BranchTaken,
  output logic            PC_Write,
  output logic            IFID_Write,
  output logic            IDEX_Bubble,
  output logic            IFID_Flush,
  output logic            MC_Start,
  output logic            MC_Done,
  output logic [4:0]      MC_WriteRegister,
  output logic            MC_Busy,
  output logic [NREG-1:0] Pending,
  output logic [15:0]     StallCycles
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // Counter is loaded in the MC_Start cycle and reaches zero in the MC_Done cycle.
  localparam logic [3:0] CNT_LOAD = 4'(MC_LAT - 1);

  logic [0:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            start_q, start_d;
  logic [4:0]      mc_wr_q, mc_wr_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  logic lu, sb, st, stall, issue, done;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [NREG-1:0] reg_mask(input logic [4:0] r);
    logic [NREG-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

  // Hazard detection (current inputs and state)
  always_comb begin
    done  = (state_q == S_BUSY) && (cnt_q == 4'd0);
    lu    = EX_MemRead && (EX_WriteRegister != 5'd0) &&
            ((ID_UseRs && (ID_rs == EX_WriteRegister)) ||
             (ID_UseRt && (ID_rt == EX_WriteRegister)));
    // Last term is the write-after-write check against the in-flight result.
    sb    = (ID_UseRs && pending_q[ID_rs]) ||
            (ID_UseRt && pending_q[ID_rt]) ||
            (ID_RegWrite && pending_q[ID_WriteRegister]);
    // The unit frees up in its MC_Done cycle, so a new op may issue there.
    st    = ID_MultiCycle && (state_q == S_BUSY) && !done;
    stall = ID_Valid && (lu || sb || st) && !EX_BranchTaken;
    issue = ID_Valid && ID_MultiCycle && !stall && !EX_BranchTaken;
  end

  // Pipeline control outputs
  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    if (!reset) begin
      if (EX_BranchTaken) begin
        IFID_Flush  = 1'b1;
        IDEX_Bubble = 1'b1;
      end else if (stall) begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b1;
      end
    end
  end

  // Next-state logic for the sequencer and scoreboard
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_d     = issue;
    mc_wr_d     = mc_wr_q;
    pending_d   = pending_q;
    stall_cnt_d = stall ? sat_inc16(stall_cnt_q) : stall_cnt_q;

    if (state_q == S_BUSY && cnt_q != 4'd0)
      cnt_d = cnt_q - 4'd1;

    if (done) begin
      state_d   = S_IDLE;
      pending_d = pending_d & ~reg_mask(mc_wr_q);
    end

    // Applied after the clear so a same-register re-issue keeps its bit.
    if (issue) begin
      state_d = S_BUSY;
      cnt_d   = CNT_LOAD;
      mc_wr_d = ID_WriteRegister;
      if (ID_RegWrite && ID_WriteRegister != 5'd0)
        pending_d = pending_d | reg_mask(ID_WriteRegister);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      start_q     <= 1'b0;
      mc_wr_q     <= 5'd0;
      pending_q   <= '0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      mc_wr_q     <= mc_wr_d;
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MC_Start         = start_q;
  // Reset drops an in-flight op, so its completion must never be seen.
  assign MC_Done          = done && !reset;
  assign MC_Busy          = (state_q == S_BUSY);
  assign MC_WriteRegister = mc_wr_q;
  assign Pending          = pending_q;
  assign StallCycles      = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk;
  logic        reset;
  logic        ID_Valid;
  logic [4:0]  ID_rs, ID_rt;
  logic        ID_UseRs, ID_UseRt;
  logic        ID_MultiCycle, ID_RegWrite;
  logic [4:0]  ID_WriteRegister;
  logic        EX_MemRead;
  logic [4:0]  EX_WriteRegister;
  logic        EX_BranchTaken;
  logic        PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush;
  logic        MC_Start, MC_Done, MC_Busy;
  logic [4:0]  MC_WriteRegister;
  logic [31:0] Pending;
  logic [15:0] StallCycles;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard #(.MC_LAT(4), .NREG(32)) dut (
    .clk(clk), .reset(reset),
    .ID_Valid(ID_Valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .ID_MultiCycle(ID_MultiCycle), .ID_RegWrite(ID_RegWrite),
    .ID_WriteRegister(ID_WriteRegister),
    .EX_MemRead(EX_MemRead), .EX_WriteRegister(EX_WriteRegister),
    .EX_BranchTaken(EX_BranchTaken),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write),
    .IDEX_Bubble(IDEX_Bubble), .IFID_Flush(IFID_Flush),
    .MC_Start(MC_Start), .MC_Done(MC_Done),
    .MC_WriteRegister(MC_WriteRegister), .MC_Busy(MC_Busy),
    .Pending(Pending), .StallCycles(StallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ID_Valid = 0; ID_rs = 0; ID_rt = 0; ID_UseRs = 0; ID_UseRt = 0;
    ID_MultiCycle = 0; ID_RegWrite = 0; ID_WriteRegister = 0;
    EX_MemRead = 0; EX_WriteRegister = 0; EX_BranchTaken = 0;
  endtask

  task automatic mc_issue_inputs(input logic [4:0] wr);
    idle_inputs();
    ID_Valid = 1; ID_MultiCycle = 1; ID_RegWrite = 1; ID_WriteRegister = wr;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    ID_Valid = 1; ID_rs = 5; ID_UseRs = 1; EX_MemRead = 1; EX_WriteRegister = 5;
    tick(); tick();
    #1;
    total++;
    if ({PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush} !== 4'b1100) begin
      bad++; $display("FAIL reset_forced_ctrl got=%b exp=1100", {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush});
    end
    reset = 0;
    idle_inputs();
    #1;
    total++;
    if ({MC_Start, MC_Done, MC_Busy} !== 3'b000 || MC_WriteRegister !== 5'd0) begin
      bad++; $display("FAIL reset_mc got=%b/%0d exp=000/0", {MC_Start, MC_Done, MC_Busy}, MC_WriteRegister);
    end
    total++;
    if (Pending !== 32'd0 || StallCycles !== 16'd0) begin
      bad++; $display("FAIL reset_regs got=%h/%0d exp=0/0", Pending, StallCycles);
    end
  endtask

  task automatic test_load_use();
    tick();
    ID_Valid = 1; ID_rs = 5; ID_UseRs = 1; EX_MemRead = 1; EX_WriteRegister = 5;
    #1;
    total++;
    if ({PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush} !== 4'b0010) begin
      bad++; $display("FAIL lu_rs_stall got=%b exp=0010", {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush});
    end
    tick();
    EX_MemRead = 0; EX_WriteRegister = 0;
    #1;
    total++;
    if ({PC_Write, IFID_Write, IDEX_Bubble} !== 3'b110) begin
      bad++; $display("FAIL lu_one_cycle got=%b exp=110", {PC_Write, IFID_Write, IDEX_Bubble});
    end
    idle_inputs();
    ID_Valid = 1; ID_rs = 0; ID_UseRs = 1; EX_MemRead = 1; EX_WriteRegister = 0;
    #1;
    total++;
    if ({PC_Write, IDEX_Bubble} !== 2'b10) begin
      bad++; $display("FAIL lu_r0_nostall got=%b exp=10", {PC_Write, IDEX_Bubble});
    end
    idle_inputs();
    ID_Valid = 1; ID_rt = 7; ID_UseRt = 1; EX_MemRead = 1; EX_WriteRegister = 7;
    #1;
    total++;
    if ({PC_Write, IFID_Write, IDEX_Bubble} !== 3'b001) begin
      bad++; $display("FAIL lu_rt_stall got=%b exp=001", {PC_Write, IFID_Write, IDEX_Bubble});
    end
    tick();
    ID_UseRt = 0;
    #1;
    total++;
    if (PC_Write !== 1'b1) begin
      bad++; $display("FAIL lu_unused_rt got=%b exp=1", PC_Write);
    end
    total++;
    if (StallCycles !== 16'd2) begin
      bad++; $display("FAIL lu_stallcount got=%0d exp=2", StallCycles);
    end
    idle_inputs();
  endtask

  task automatic test_mc_dependency();
    tick();
    mc_issue_inputs(5'd9);
    #1;
    total++;
    if (PC_Write !== 1'b1 || MC_Busy !== 1'b0) begin
      bad++; $display("FAIL mc_issue_T got=%b%b exp=10", PC_Write, MC_Busy);
    end
    tick();
    idle_inputs();
    ID_Valid = 1; ID_rt = 9; ID_UseRt = 1; ID_RegWrite = 1; ID_WriteRegister = 3;
    #1;
    total++;
    if ({MC_Start, MC_Busy, MC_Done, Pending[9], PC_Write} !== 5'b11010) begin
      bad++; $display("FAIL mc_T1 got=%b exp=11010", {MC_Start, MC_Busy, MC_Done, Pending[9], PC_Write});
    end
    for (int c = 2; c <= 3; c++) begin
      tick();
      total++;
      if ({MC_Start, MC_Busy, MC_Done, PC_Write, IDEX_Bubble} !== 5'b01001) begin
        bad++; $display("FAIL mc_T%0d got=%b exp=01001", c, {MC_Start, MC_Busy, MC_Done, PC_Write, IDEX_Bubble});
      end
    end
    tick();
    total++;
    if ({MC_Done, MC_Busy, PC_Write} !== 3'b110 || MC_WriteRegister !== 5'd9) begin
      bad++; $display("FAIL mc_T4_done got=%b/%0d exp=110/9", {MC_Done, MC_Busy, PC_Write}, MC_WriteRegister);
    end
    tick();
    total++;
    if ({Pending[9], MC_Busy, MC_Done, PC_Write} !== 4'b0001) begin
      bad++; $display("FAIL mc_T5_release got=%b exp=0001", {Pending[9], MC_Busy, MC_Done, PC_Write});
    end
    total++;
    if (StallCycles !== 16'd6) begin
      bad++; $display("FAIL mc_stallcount got=%0d exp=6", StallCycles);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    tick();
    mc_issue_inputs(5'd9);
    tick();
    mc_issue_inputs(5'd12);
    #1;
    total++;
    if ({MC_Start, PC_Write, IDEX_Bubble} !== 3'b101) begin
      bad++; $display("FAIL b2b_T1_struct got=%b exp=101", {MC_Start, PC_Write, IDEX_Bubble});
    end
    tick(); tick();
    total++;
    if (PC_Write !== 1'b0) begin
      bad++; $display("FAIL b2b_T3_struct got=%b exp=0", PC_Write);
    end
    tick();
    total++;
    if ({MC_Done, MC_Busy, PC_Write, IDEX_Bubble} !== 4'b1110) begin
      bad++; $display("FAIL b2b_T4_issue got=%b exp=1110", {MC_Done, MC_Busy, PC_Write, IDEX_Bubble});
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if ({MC_Start, MC_Busy, MC_Done} !== 3'b110 || MC_WriteRegister !== 5'd12 || Pending !== 32'h0000_1000) begin
      bad++; $display("FAIL b2b_T5 got=%b/%0d/%h exp=110/12/00001000", {MC_Start, MC_Busy, MC_Done}, MC_WriteRegister, Pending);
    end
    tick(); tick(); tick();
    total++;
    if (MC_Done !== 1'b1 || MC_WriteRegister !== 5'd12) begin
      bad++; $display("FAIL b2b_T8_done got=%b/%0d exp=1/12", MC_Done, MC_WriteRegister);
    end
    tick();
    total++;
    if (Pending !== 32'd0 || MC_Busy !== 1'b0 || StallCycles !== 16'd9) begin
      bad++; $display("FAIL b2b_T9 got=%h/%b/%0d exp=0/0/9", Pending, MC_Busy, StallCycles);
    end
  endtask

  task automatic test_flush();
    tick();
    mc_issue_inputs(5'd9);
    tick();
    idle_inputs();
    ID_Valid = 1; ID_rs = 5; ID_UseRs = 1; ID_MultiCycle = 1;
    EX_MemRead = 1; EX_WriteRegister = 5; EX_BranchTaken = 1;
    #1;
    total++;
    if ({PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush} !== 4'b1111) begin
      bad++; $display("FAIL flush_over_stall got=%b exp=1111", {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush});
    end
    tick();
    idle_inputs();
    tick(); tick();
    total++;
    if (MC_Done !== 1'b1 || MC_WriteRegister !== 5'd9) begin
      bad++; $display("FAIL flush_mc_survives got=%b/%0d exp=1/9", MC_Done, MC_WriteRegister);
    end
    tick();
    ID_Valid = 1; ID_MultiCycle = 1; ID_RegWrite = 1; ID_WriteRegister = 4; EX_BranchTaken = 1;
    tick();
    idle_inputs();
    #1;
    total++;
    if ({MC_Start, MC_Busy} !== 2'b00 || Pending !== 32'd0 || StallCycles !== 16'd9) begin
      bad++; $display("FAIL flush_no_issue got=%b/%h/%0d exp=00/0/9", {MC_Start, MC_Busy}, Pending, StallCycles);
    end
  endtask

  task automatic test_reset_mid_busy();
    tick();
    mc_issue_inputs(5'd9);
    tick();
    idle_inputs();
    tick();
    reset = 1;
    #1;
    total++;
    if ({PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush} !== 4'b1100) begin
      bad++; $display("FAIL rst_mid_ctrl got=%b exp=1100", {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush});
    end
    tick();
    reset = 0;
    #1;
    total++;
    if (MC_Busy !== 1'b0 || Pending !== 32'd0 || StallCycles !== 16'd0) begin
      bad++; $display("FAIL rst_mid_state got=%b/%h/%0d exp=0/0/0", MC_Busy, Pending, StallCycles);
    end
    for (int c = 0; c < 6; c++) begin
      total++;
      if (MC_Done !== 1'b0) begin
        bad++; $display("FAIL rst_mid_no_done cycle=%0d got=%b exp=0", c, MC_Done);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    idle_inputs();
    ID_Valid = 1; ID_rs = 6; ID_UseRs = 1; EX_MemRead = 1; EX_WriteRegister = 6;
    repeat (65534) @(posedge clk);
    #1;
    total++;
    if (StallCycles !== 16'hFFFE) begin
      bad++; $display("FAIL sat_near got=%h exp=fffe", StallCycles);
    end
    tick();
    total++;
    if (StallCycles !== 16'hFFFF) begin
      bad++; $display("FAIL sat_reach got=%h exp=ffff", StallCycles);
    end
    repeat (4465) @(posedge clk);
    #1;
    total++;
    if (StallCycles !== 16'hFFFF) begin
      bad++; $display("FAIL sat_hold got=%h exp=ffff", StallCycles);
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_mc_dependency();
    test_back_to_back();
    test_flush();
    test_reset_mid_busy();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Decode-stage interlock and multi-cycle writeback sequencer for the 5-stage pipeline. It sits beside the forwarding logic and is the producer-side counterpart. Forwarding resolves operands whose results are already in MEM/WB. This block stalls or bubbles the pipeline for results that cannot be forwarded yet: load-use, and in-flight multi-cycle (SHA round) ops. It also sequences the multi-cycle unit and announces its writeback register.

## Interface
- MC_LAT, 4: multi-cycle op latency in cycles, from MC_Start to MC_Done inclusive; legal range 2..15.
- NREG, 32: architectural registers; register 0 is never pending.
- clk  in  1  pipeline clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- ID_Valid  in  1  ID stage holds a real instruction.
- ID_rs, ID_rt  in  5  ID source registers.
- ID_UseRs, ID_UseRt  in  1  the corresponding source is actually read.
- ID_MultiCycle  in  1  ID instruction is a multi-cycle op.
- ID_RegWrite  in  1  ID instruction writes a register.
- ID_WriteRegister  in  5  ID destination register.
- EX_MemRead  in  1  EX instruction is a load.
- EX_WriteRegister  in  5  EX destination register.
- EX_BranchTaken  in  1  branch resolved taken in EX.
- PC_Write  out  1  PC update enable.
- IFID_Write  out  1  IF/ID register enable.
- IDEX_Bubble  out  1  zero the control fields of ID/EX.
- IFID_Flush  out  1  squash IF/ID.
- MC_Start  out  1  one-cycle launch pulse to the multi-cycle unit.
- MC_Done  out  1  one-cycle pulse; multi-cycle result is valid for WB.
- MC_WriteRegister  out  5  destination register of the in-flight op; held through MC_Done.
- MC_Busy  out  1  a multi-cycle op is in flight.
- Pending  out  NREG  scoreboard bit vector.
- StallCycles  out  16  saturating count of stall cycles.

## Operation
- Load-use hazard (LU) is asserted when all of the following hold:
  - EX_MemRead is 1 and EX_WriteRegister is non-zero.
  - Either ID_UseRs is 1 and ID_rs equals EX_WriteRegister, or ID_UseRt is 1 and ID_rt equals EX_WriteRegister.
- Scoreboard hazard (SB) is asserted when either holds:
  - ID_UseRs is 1 and Pending[ID_rs] is 1.
  - ID_UseRt is 1 and Pending[ID_rt] is 1.
- Write-after-write check: SB is also asserted when ID_RegWrite is 1 and Pending[ID_WriteRegister] is 1.
- Structural hazard (ST): ID_MultiCycle is 1 while in BUSY, except in the MC_Done cycle.
- stall = ID_Valid & (LU | SB | ST) & !EX_BranchTaken.
- During stall: PC_Write=0, IFID_Write=0, IDEX_Bubble=1.
- Flush: EX_BranchTaken drives IFID_Flush=1 and IDEX_Bubble=1 with PC_Write=1 and IFID_Write=1. Flush overrides stall.
- issue = ID_Valid & ID_MultiCycle & !stall & !EX_BranchTaken.
- On issue:
  - Capture ID_WriteRegister into MC_WriteRegister.
  - If ID_RegWrite is 1 and the destination is non-zero, set its Pending bit.
  - Enter BUSY.
- FSM has two states:
  - IDLE goes to BUSY on issue.
  - BUSY goes to IDLE when count=0 with no issue.
  - BUSY stays BUSY (re-armed) when count=0 and issue occurs in the same cycle.
- An in-flight op is never cancelled by EX_BranchTaken; it is older than the branch.
- StallCycles increments on each stall cycle and saturates at 16'hFFFF.

## Timing
- Hazard and flush outputs (PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush) are combinational from current inputs and state.
- Issue in cycle T produces:
  - MC_Start=1 in T+1 only.
  - count loaded with MC_LAT-1 in T+1, decrementing each cycle.
  - MC_Busy=1 from T+1 through T+MC_LAT.
  - MC_Done=1 in T+MC_LAT only (count=0).
- The Pending bit clears at the end of the MC_Done cycle. A dependent instruction in ID therefore stalls through T+MC_LAT and proceeds at T+MC_LAT+1.
- Same-cycle completion and issue: the old bit clears and the new bit sets. If it is the same register, set wins.
- Reset values: Pending=0, IDLE, count=0, MC_Start=0, MC_Done=0, MC_Busy=0, MC_WriteRegister=0, StallCycles=0.
- While reset is high, outputs are forced to PC_Write=1, IFID_Write=1, IDEX_Bubble=0, IFID_Flush=0. This applies mid-operation too: any in-flight op is dropped with no MC_Done.

## Test plan
- Load-use: EX_MemRead=1, EX_WriteRegister=5, ID_rs=5, ID_UseRs=1 -> exactly one cycle with PC_Write=0, IFID_Write=0, IDEX_Bubble=1; with EX_WriteRegister=0 -> no stall.
- Multi-cycle dependency: issue with ID_WriteRegister=9 at T, then ID_rt=9 (ID_UseRt=1) at T+1 -> MC_Start at T+1, MC_Done and MC_WriteRegister=9 at T+4, stall during T+1..T+4, Pending[9]=0 at T+5, and StallCycles=4.
- Back-to-back multi-cycle: second op waits in ID until T+4 and issues there -> MC_Start at T+5 with no gap in MC_Busy; Pending swaps register 9 for 12 cleanly.
- Branch flush during stall: LU active and EX_BranchTaken=1 -> IFID_Flush=1, PC_Write=1, no issue; the in-flight op still delivers MC_Done.
- Reset mid-BUSY at T+2 -> in the next cycle MC_Busy=0, Pending=0, and no MC_Done ever appears.
- Saturation: hold stall for 70000 cycles -> StallCycles=16'hFFFF.
